// File: rtl/alu_logic_pkg.sv
// Shared definitions for the bitwise logic unit: op select width and encodings.
package alu_logic_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'd6;  // x & ~y
  localparam logic [OP_W-1:0] OP_PASSX = 3'd7;

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/data register slice of an elastic pipeline. The slice advances when it is empty or
// when the slice downstream of it advances, so bubbles collapse during a stall.
module logic_pipe_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         next_adv,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         adv
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Advance when empty or when the downstream slice takes our contents
  always_comb begin
    adv   = !valid_q || next_adv;
    valid = valid_q;
    data  = data_q;
  end

  // Capture upstream contents on advance; data only moves with a real transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready on both sides. The result and its zero/parity
// flags are formed at the input and carried through PIPE elastic register slices.
module logic_unit_pipe
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PIPE  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           op,
  input  logic [WIDTH-1:0]          x,
  input  logic [WIDTH-1:0]          y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out,
  output logic                      zero,
  output logic                      parity,
  output logic [$clog2(PIPE+1)-1:0] occupancy
);

  localparam int unsigned PW    = WIDTH + 2;
  localparam int unsigned OCC_W = $clog2(PIPE + 1);

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_parity;

  logic             stage_valid [PIPE];
  logic             stage_adv   [PIPE];
  logic [PW-1:0]    stage_data  [PIPE];

  // Decode the operation on the incoming operands
  always_comb begin
    res = x;
    case (op)
      OP_AND:   res = x & y;
      OP_OR:    res = x | y;
      OP_XOR:   res = x ^ y;
      OP_XNOR:  res = ~(x ^ y);
      OP_NAND:  res = ~(x & y);
      OP_NOR:   res = ~(x | y);
      OP_ANDN:  res = x & ~y;
      OP_PASSX: res = x;
      default:  res = x;
    endcase
  end

  // Flags are formed once here and ride along with the result
  always_comb begin
    res_zero   = ~|res;
    res_parity = ^res;
  end

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    logic          s_in_valid;
    logic [PW-1:0] s_in_data;
    logic          s_next_adv;

    if (k == 0) begin : g_head
      assign s_in_valid = in_valid;
      assign s_in_data  = {res, res_zero, res_parity};
    end else begin : g_body
      assign s_in_valid = stage_valid[k-1];
      assign s_in_data  = stage_data[k-1];
    end

    if (k == PIPE - 1) begin : g_tail
      assign s_next_adv = out_ready;
    end else begin : g_mid
      assign s_next_adv = stage_adv[k+1];
    end

    logic_pipe_stage #(
      .W(PW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s_in_valid),
      .in_data  (s_in_data),
      .next_adv (s_next_adv),
      .valid    (stage_valid[k]),
      .data     (stage_data[k]),
      .adv      (stage_adv[k])
    );
  end

  // Handshake outputs and the result taken from the last slice
  always_comb begin
    in_ready               = !stage_valid[0] || stage_adv[0];
    out_valid              = stage_valid[PIPE-1];
    {out, zero, parity}    = stage_data[PIPE-1];
  end

  // Occupancy is simply the number of occupied slices
  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < PIPE; i++) begin
      occupancy = occupancy + OCC_W'(stage_valid[i]);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: main 32/2 instance plus 1/1 and 64/4 corner instances.
module tb_logic_unit_pipe;

  localparam int P = 2;
  localparam int N_CORNER = 10000;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        p;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic        in_valid, in_ready, out_valid, out_ready, zero, parity;
  logic [2:0]  op;
  logic [31:0] x, y, out;
  logic [1:0]  occupancy;
  // WIDTH=1, PIPE=1
  logic        c1_in_valid, c1_in_ready, c1_out_valid, c1_out_ready, c1_zero, c1_parity;
  logic [2:0]  c1_op;
  logic [0:0]  c1_x, c1_y, c1_out, c1_occ;
  // WIDTH=64, PIPE=4
  logic        c4_in_valid, c4_in_ready, c4_out_valid, c4_out_ready, c4_zero, c4_parity;
  logic [2:0]  c4_op;
  logic [63:0] c4_x, c4_y, c4_out;
  logic [2:0]  c4_occ;

  logic_unit_pipe #(.WIDTH(32), .PIPE(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero), .parity(parity),
    .occupancy(occupancy)
  );

  logic_unit_pipe #(.WIDTH(1), .PIPE(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(c1_in_valid), .in_ready(c1_in_ready), .op(c1_op),
    .x(c1_x), .y(c1_y), .out_valid(c1_out_valid), .out_ready(c1_out_ready), .out(c1_out),
    .zero(c1_zero), .parity(c1_parity), .occupancy(c1_occ)
  );

  logic_unit_pipe #(.WIDTH(64), .PIPE(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(c4_in_valid), .in_ready(c4_in_ready), .op(c4_op),
    .x(c4_x), .y(c4_y), .out_valid(c4_out_valid), .out_ready(c4_out_ready), .out(c4_out),
    .zero(c4_zero), .parity(c4_parity), .occupancy(c4_occ)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_main = 0, r1 = 0, r4 = 0;
  exp_t mq[$], q1[$], q4[$];

  bit          chk_lat = 0;
  bit          tab_en = 0;
  logic [31:0] tab_res;
  logic        tab_z, tab_p;
  logic        stall_prev = 0;
  logic [33:0] held;

  logic [31:0] sweep_tab [8] = '{32'hF000_000F, 32'hFFF0_0FFF, 32'h0FF0_0FF0, 32'hF00F_F00F,
                                 32'h0FFF_FFF0, 32'h000F_F000, 32'h00F0_00F0, 32'hF0F0_00FF};

  function automatic logic [63:0] model(logic [2:0] o, logic [63:0] a, logic [63:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // main scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] m;
    if (rst) begin
      mq.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || {out, zero, parity} !== held) begin
          failures++;
          $display("FAIL hold: valid=%b data=%h required 1 %h", out_valid, {out, zero, parity}, held);
        end
      end
      checks++;
      if (occupancy !== 2'(mq.size())) begin
        failures++;
        $display("FAIL occupancy: got %0d required %0d", occupancy, mq.size());
      end
      checks++;
      if (in_ready !== ((mq.size() == P && !out_ready) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL in_ready: got %b occ=%0d out_ready=%b", in_ready, mq.size(), out_ready);
      end
      if (out_valid === 1'b1 && out_ready) begin
        rx_main++;
        checks++;
        if (mq.size() == 0) begin
          failures++;
          $display("FAIL spurious_out: got %h required no output", out);
        end else begin
          e = mq.pop_front();
          if (out !== e.res[31:0] || zero !== e.z || parity !== e.p) begin
            failures++;
            $display("FAIL result: got %h z=%b p=%b required %h z=%b p=%b",
                     out, zero, parity, e.res[31:0], e.z, e.p);
          end
          if (chk_lat) begin
            checks++;
            if (cyc - e.cyc != P) begin
              failures++;
              $display("FAIL latency: got %0d required %0d", cyc - e.cyc, P);
            end
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        m = model(op, {32'b0, x}, {32'b0, y});
        e.res = tab_en ? {32'b0, tab_res} : {32'b0, m[31:0]};
        e.z   = tab_en ? tab_z : (m[31:0] == 32'b0);
        e.p   = tab_en ? tab_p : ^m[31:0];
        e.cyc = cyc;
        mq.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      held = {out, zero, parity};
    end
  end

  // corner scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] m;
    if (rst) begin
      q1.delete();
      q4.delete();
    end else begin
      checks++;
      if (c1_occ !== 1'(q1.size()) || c4_occ !== 3'(q4.size())) begin
        failures++;
        $display("FAIL corner_occ: got %0d/%0d required %0d/%0d", c1_occ, c4_occ, q1.size(), q4.size());
      end
      checks++;
      if (c4_in_ready !== ((q4.size() == 4 && !c4_out_ready) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL c4_in_ready: got %b occ=%0d", c4_in_ready, q4.size());
      end
      if (c1_out_valid === 1'b1 && c1_out_ready) begin
        r1++;
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL c1_spurious: got %b required no output", c1_out);
        end else begin
          e = q1.pop_front();
          if (c1_out !== e.res[0] || c1_zero !== e.z || c1_parity !== e.p) begin
            failures++;
            $display("FAIL c1_result: got %b z=%b p=%b required %b z=%b p=%b",
                     c1_out, c1_zero, c1_parity, e.res[0], e.z, e.p);
          end
        end
      end
      if (c4_out_valid === 1'b1 && c4_out_ready) begin
        r4++;
        checks++;
        if (q4.size() == 0) begin
          failures++;
          $display("FAIL c4_spurious: got %h required no output", c4_out);
        end else begin
          e = q4.pop_front();
          if (c4_out !== e.res || c4_zero !== e.z || c4_parity !== e.p) begin
            failures++;
            $display("FAIL c4_result: got %h z=%b p=%b required %h z=%b p=%b",
                     c4_out, c4_zero, c4_parity, e.res, e.z, e.p);
          end
        end
      end
      if (c1_in_valid && c1_in_ready === 1'b1) begin
        m = model(c1_op, {63'b0, c1_x}, {63'b0, c1_y});
        e.res = {63'b0, m[0]};
        e.z   = ~m[0];
        e.p   = m[0];
        e.cyc = cyc;
        q1.push_back(e);
      end
      if (c4_in_valid && c4_in_ready === 1'b1) begin
        m = model(c4_op, c4_x, c4_y);
        e.res = m;
        e.z   = (m == 64'b0);
        e.p   = ^m;
        e.cyc = cyc;
        q4.push_back(e);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        out !== 32'b0 || zero !== 1'b0 || parity !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b occ=%0d rdy=%b out=%h z=%b p=%b required 0 0 1 0 0 0",
               out_valid, occupancy, in_ready, out, zero, parity);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd1;
    x = 32'h1111_2222;
    y = 32'h0000_F000;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("FAIL midflight_fill: got occ=%0d required 2", occupancy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midflight_reset: got v=%b occ=%0d rdy=%b required 0 0 1",
               out_valid, occupancy, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out !== 32'b0) begin
      failures++;
      $display("FAIL midflight_hold_reset: got v=%b occ=%0d rdy=%b out=%h required 0 0 1 0",
               out_valid, occupancy, in_ready, out);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_op_sweep();
    out_ready = 1'b1;
    x = 32'hF0F0_00FF;
    y = 32'hFF00_0F0F;
    chk_lat = 1;
    tab_en = 1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      tab_res = sweep_tab[i];
      tab_z = (sweep_tab[i] == 32'b0);
      tab_p = ^sweep_tab[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (mq.size() != 0) begin
      failures++;
      $display("FAIL sweep_drain: got %0d pending required 0", mq.size());
    end
    chk_lat = 0;
    tab_en = 0;
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    tab_en = 1;
    in_valid = 1'b1;
    op = 3'd2;
    x = 32'h1234_5678;
    y = 32'h1234_5678;
    tab_res = 32'h0;
    tab_z = 1'b1;
    tab_p = 1'b0;
    @(posedge clk);
    #1;
    op = 3'd0;
    x = 32'h0000_0007;
    y = 32'hFFFF_FFFF;
    tab_res = 32'h7;
    tab_z = 1'b0;
    tab_p = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (mq.size() != 0) begin
      failures++;
      $display("FAIL flags_drain: got %0d pending required 0", mq.size());
    end
    tab_en = 0;
  endtask

  task automatic test_stall();
    int sent = 0;
    int rx0 = rx_main;
    out_ready = 1'b0;
    y = 32'h0F0F_3C3C;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      op = 3'(sent);
      x = 32'hA5A5_0000 | 32'(sent);
      @(negedge clk);
      if (in_ready === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (sent != 2 || in_ready !== 1'b0 || occupancy !== 2'd2) begin
      failures++;
      $display("FAIL stall_full: got accepts=%0d rdy=%b occ=%0d required 2 0 2",
               sent, in_ready, occupancy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sent < 5; c++) begin
      op = 3'(sent);
      x = 32'hA5A5_0000 | 32'(sent);
      @(negedge clk);
      if (in_ready === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (rx_main - rx0 != 5 || mq.size() != 0) begin
      failures++;
      $display("FAIL stall_count: got %0d outputs %0d pending required 5 0", rx_main - rx0, mq.size());
    end
  endtask

  task automatic test_full_simul();
    int sent = 0;
    out_ready = 1'b0;
    op = 3'd5;
    y = 32'h00FF_00FF;
    for (int c = 0; c < 10 && sent < 2; c++) begin
      in_valid = 1'b1;
      x = 32'h1357_0000 | 32'(sent);
      @(negedge clk);
      if (in_ready === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("FAIL full_fill: got occ=%0d required 2", occupancy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      x = 32'h2468_0000 | 32'(c);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL full_simul: got rdy=%b v=%b required 1 1", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (occupancy !== 2'd2) begin
        failures++;
        $display("FAIL full_occ: got occ=%0d required 2", occupancy);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() != 0; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_corners();
    int s1 = 0, s4 = 0;
    int budget;
    bit a1, a4;
    for (budget = 0; budget < 40000 && (r1 < N_CORNER || r4 < N_CORNER); budget++) begin
      @(negedge clk);
      a1 = c1_in_valid && c1_in_ready;
      a4 = c4_in_valid && c4_in_ready;
      @(posedge clk);
      #1;
      if (a1) s1++;
      if (a4) s4++;
      if (!c1_in_valid || a1) begin
        c1_in_valid = (s1 < N_CORNER) && ($urandom_range(3) != 0);
        c1_op = 3'($urandom);
        c1_x = 1'($urandom);
        c1_y = 1'($urandom);
      end
      if (!c4_in_valid || a4) begin
        c4_in_valid = (s4 < N_CORNER) && ($urandom_range(3) != 0);
        c4_op = 3'($urandom);
        c4_x = {$urandom, $urandom};
        c4_y = {$urandom, $urandom};
      end
      c1_out_ready = ($urandom_range(3) != 0);
      c4_out_ready = ($urandom_range(3) != 0);
    end
    c1_in_valid = 1'b0;
    c4_in_valid = 1'b0;
    checks++;
    if (r1 != N_CORNER || r4 != N_CORNER || q1.size() != 0 || q4.size() != 0) begin
      failures++;
      $display("FAIL corner_totals: got %0d/%0d outputs %0d/%0d pending required %0d each 0 pending",
               r1, r4, q1.size(), q4.size(), N_CORNER);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; x = 32'b0; y = 32'b0;
    c1_in_valid = 1'b0; c1_out_ready = 1'b1; c1_op = 3'd0; c1_x = 1'b0; c1_y = 1'b0;
    c4_in_valid = 1'b0; c4_out_ready = 1'b1; c4_op = 3'd0; c4_x = 64'b0; c4_y = 64'b0;
    test_reset();
    test_reset_midflight();
    test_op_sweep();
    test_flags();
    test_stall();
    test_full_simul();
    test_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
